wb_spi_master: RTL and testbench
================================

# wb_spi_master

Parametrised Wishbone SPI master, successor to the fixed 8-bit/mode-0 SPI port. It adds configurable frame length, all four SPI modes (CPOL/CPHA), MSB/LSB-first shifting, a wide clock divisor and multiple chip selects, all behind a register file on the 32-bit Wishbone slave bus. It sits on the peripheral Wishbone segment next to the other simple slaves.

## Interface
- `DATA_W`, 32: maximum frame length in bits, 8..32.
- `NCS`, 4: number of chip-select outputs, 1..8.
- `DIV_W`, 16: divisor register width.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `wb_adr_i` in 32: byte address; only `[4:2]` is decoded.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_sel_i` in 4: ignored; all accesses are full-word.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: standard Wishbone classic strobes.
- `wb_ack_o` out 1: `wb_stb_i & wb_cyc_i & ack`.
- `spi_sck` out 1: serial clock; idles at CPOL.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.
- `spi_cs_n` out NCS: active-low chip selects.

## Operation
- Register map (word offsets):
  - 0 DATA: write loads TX and starts a frame; read returns the last RX frame, right-aligned.
  - 1 STATUS (RO): bit0 busy, bit1 rx_valid, bit2 wcol.
  - 2 CS: bits `[NCS-1:0]`; a 1 drives the corresponding `spi_cs_n` low.
  - 3 DIV: sck half-period = DIV+1 clk cycles.
  - 4 CTRL: bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST, bits `[12:8]` LEN, where frame bits = LEN+1, clamped to DATA_W.
- Unmapped offsets read 0; writes to them are ignored.
- FSM states:
  - IDLE: on a DATA write, → LEAD.
  - LEAD → TRAIL, on each half-period expiry.
  - TRAIL → LEAD, or → IDLE after the last bit.
- CPHA=0: first bit is driven on MOSI at start; sample on the leading edge, shift on the trailing edge.
- CPHA=1: shift on the leading edge, sample on the trailing edge.
- Shift direction: MSB-first by default. LSB_FIRST shifts from bit 0. With MSB-first, the first bit sent is bit LEN.
- End of frame: rx_valid is set and busy is cleared. Reading DATA clears rx_valid.
- Write to DATA while busy: data is dropped and wcol is set. Reading STATUS clears wcol.
- Writes to CTRL or DIV while busy are ignored. CS writes always take effect; the chip select is under software control and is not toggled automatically.
- Reset values: sck = 0, mosi = 0, `spi_cs_n` all 1, ack = 0, `wb_dat_o` = 0, DIV = all ones, CTRL = 0x0700 (8-bit, mode 0, MSB-first), busy / rx_valid / wcol = 0.
- Reset mid-frame aborts immediately. sck returns to 0 (CPOL resets to 0) and no rx_valid is produced.

## Timing
- ack rises on the cycle after the strobe, provided ack was low, and falls the next cycle. Throughput is one access per 2 cycles.
- busy reads 1 starting from the cycle after the DATA-write ack.
- The first sck edge occurs DIV+1 cycles after busy rises.
- A frame lasts 2·(LEN+1)·(DIV+1) cycles. rx_valid is set on the cycle busy falls.
- The last sampled bit appears in DATA on that same cycle.
- MOSI changes only on shift edges. After the final trailing edge, MOSI holds the last bit until the next frame.
- A DATA write in the same cycle as frame completion is accepted as a new frame, without wcol.

## Configuration
- `WB_SPI_IRQ_EN` defined:
  - Adds output `spi_irq` (1 bit).
  - Adds CTRL bit16 IRQ_EN.
  - `spi_irq` = IRQ_EN & rx_valid, level-sensitive, registered.
- Not defined: no port and no register bit; CTRL bit16 reads 0.

## Structure
- Package `wb_spi_pkg` holds:
  - Register offset constants.
  - CTRL/STATUS bit-index constants.
  - FSM state typedef (IDLE/LEAD/TRAIL).
  - CTRL reset constant.
- Sub-module `spi_shift_engine` contains the divisor counter, FSM, shift register and bit counter. Its interface:
  - Inputs: start, tx, len, cpol, cpha, lsb, div.
  - Outputs: busy, done pulse, rx, sck, mosi.
- Top level: Wishbone decode and register file.

## Test plan
- Reset, then read STATUS and CTRL → 0x0 and 0x0700; sck = 0; `spi_cs_n` = 4'hF.
- Mode 0, DIV=1, CS=1, write DATA 0xA5 with MISO looped to MOSI → sck period 4 clk, 32 cycles busy, DATA reads 0xA5, `spi_cs_n` = 4'hE.
- Mode 3, LSB_FIRST, LEN=15, write 0x1234 → MOSI bit sequence 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 on trailing edges; sck idles 1.
- Write DATA twice back-to-back while busy → second write dropped; STATUS = 0x5, then 0x1 on re-read.
- Assert reset mid-frame at bit 3 → busy = 0, sck = 0, rx_valid = 0 on the next cycle.
- With `WB_SPI_IRQ_EN` and IRQ_EN = 1 → `spi_irq` rises with rx_valid, falls one cycle after the DATA read.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Shared constants and types for the Wishbone SPI master: register offsets,
// CTRL/STATUS bit positions, shift-engine FSM states and the CTRL reset value.
package wb_spi_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CS     = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int ST_BUSY = 0;
  localparam int ST_RXV  = 1;
  localparam int ST_WCOL = 2;

  localparam int CT_CPOL   = 0;
  localparam int CT_CPHA   = 1;
  localparam int CT_LSB    = 2;
  localparam int CT_LEN_LO = 8;
  localparam int CT_LEN_HI = 12;
  localparam int CT_IRQ_EN = 16;

  localparam logic [31:0] CTRL_RST = 32'h0000_0700;

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_TRAIL} spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI bit engine: half-period divisor, LEAD/TRAIL FSM, bit counter and
// RX assembly for all four CPOL/CPHA modes, MSB- or LSB-first.
module spi_shift_engine
  import wb_spi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx,
  input  logic [4:0]        len,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb,
  input  logic [DIV_W-1:0]  div,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx,
  output logic              sck,
  output logic              mosi
);

  spi_state_e        state;
  logic [DIV_W-1:0]  cnt;
  logic [4:0]        k;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_sh;
  logic              tick;

  assign tick = (cnt == div);
  assign busy = (state != S_IDLE);
  assign done = (state == S_TRAIL) && tick && (k == len);

  function automatic logic tx_bit(input logic [4:0] i);
    return lsb ? tx_r[i] : tx_r[len - i];
  endfunction

  // LSB-first frames fill from bit len downward so the result ends right-aligned.
  function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] v, input logic b);
    logic [DATA_W-1:0] r;
    if (lsb) begin
      r = v >> 1;
      r[len] = b;
    end else begin
      r = {v[DATA_W-2:0], b};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      k     <= '0;
      tx_r  <= '0;
      rx_sh <= '0;
      rx    <= '0;
      sck   <= 1'b0;
      mosi  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: sck <= cpol;
        S_LEAD: begin
          if (tick) begin
            cnt   <= '0;
            sck   <= ~cpol;
            state <= S_TRAIL;
            if (cpha) mosi  <= tx_bit(k);
            else      rx_sh <= rx_ins(rx_sh, miso);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            cnt <= '0;
            sck <= cpol;
            if (cpha) rx_sh <= rx_ins(rx_sh, miso);
            if (k == len) begin
              state <= S_IDLE;
              rx    <= cpha ? rx_ins(rx_sh, miso) : rx_sh;
            end else begin
              k     <= k + 5'd1;
              state <= S_LEAD;
              if (!cpha) mosi <= tx_bit(k + 5'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A start landing on the completing edge still lets rx capture above.
      if (start) begin
        state <= S_LEAD;
        cnt   <= '0;
        k     <= '0;
        tx_r  <= tx;
        rx_sh <= '0;
        sck   <= cpol;
        if (!cpha) mosi <= lsb ? tx[0] : tx[len];
      end
    end
  end

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone classic slave front-end and register file for the SPI master.
// Define WB_SPI_IRQ_EN to add the spi_irq output and CTRL.IRQ_EN bit.
module wb_spi_master
  import wb_spi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NCS    = 4,
  parameter int DIV_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  output logic           wb_ack_o,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic [NCS-1:0] spi_cs_n
`ifdef WB_SPI_IRQ_EN
  ,
  output logic           spi_irq
`endif
);

  localparam logic [4:0] LEN_MAX = 5'(DATA_W - 1);

  logic              ack;
  logic [NCS-1:0]    cs_r;
  logic [DIV_W-1:0]  div_r;
  logic              cpol, cpha, lsb;
  logic [4:0]        len_r, eff_len;
  logic              rx_valid, rxv_n, wcol;
  logic              busy, done;
  logic [DATA_W-1:0] rx;
  logic [31:0]       ctrl_rd, rd_mux;
  logic [2:0]        off;
  logic              req, wr, rd, start;
  logic              unused_ok;
`ifdef WB_SPI_IRQ_EN
  logic              irq_en;
`endif

  assign off      = wb_adr_i[4:2];
  assign req      = wb_cyc_i & wb_stb_i & ~ack;
  assign wr       = wb_cyc_i & wb_stb_i & ack & wb_we_i;
  assign rd       = wb_cyc_i & wb_stb_i & ack & ~wb_we_i;
  assign wb_ack_o = wb_cyc_i & wb_stb_i & ack;
  assign spi_cs_n = ~cs_r;
  assign eff_len  = (len_r > LEN_MAX) ? LEN_MAX : len_r;
  // The completing edge frees the engine, so a write there starts a new frame.
  assign start    = wr && (off == REG_DATA) && (!busy || done);
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CT_CPOL] = cpol;
    ctrl_rd[CT_CPHA] = cpha;
    ctrl_rd[CT_LSB]  = lsb;
    ctrl_rd[CT_LEN_HI:CT_LEN_LO] = len_r;
`ifdef WB_SPI_IRQ_EN
    ctrl_rd[CT_IRQ_EN] = irq_en;
`endif
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      REG_DATA:   rd_mux = 32'(rx);
      REG_STATUS: rd_mux = {29'd0, wcol, rx_valid, busy};
      REG_CS:     rd_mux = 32'(cs_r);
      REG_DIV:    rd_mux = 32'(div_r);
      REG_CTRL:   rd_mux = ctrl_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    rxv_n = rx_valid;
    if (rd && off == REG_DATA) rxv_n = 1'b0;
    if (done)                  rxv_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= 1'b0;
      wb_dat_o <= '0;
      cs_r     <= '0;
      div_r    <= '1;
      cpol     <= CTRL_RST[CT_CPOL];
      cpha     <= CTRL_RST[CT_CPHA];
      lsb      <= CTRL_RST[CT_LSB];
      len_r    <= CTRL_RST[CT_LEN_HI:CT_LEN_LO];
      rx_valid <= 1'b0;
      wcol     <= 1'b0;
`ifdef WB_SPI_IRQ_EN
      irq_en   <= 1'b0;
      spi_irq  <= 1'b0;
`endif
    end else begin
      ack      <= req;
      if (req) wb_dat_o <= rd_mux;
      rx_valid <= rxv_n;
      if (rd && off == REG_STATUS) wcol <= 1'b0;
      if (wr) begin
        case (off)
          REG_DATA: if (busy && !done) wcol <= 1'b1;
          REG_CS:   cs_r <= wb_dat_i[NCS-1:0];
          REG_DIV:  if (!busy) div_r <= wb_dat_i[DIV_W-1:0];
          REG_CTRL: if (!busy) begin
            cpol  <= wb_dat_i[CT_CPOL];
            cpha  <= wb_dat_i[CT_CPHA];
            lsb   <= wb_dat_i[CT_LSB];
            len_r <= wb_dat_i[CT_LEN_HI:CT_LEN_LO];
`ifdef WB_SPI_IRQ_EN
            irq_en <= wb_dat_i[CT_IRQ_EN];
`endif
          end
          default: ;
        endcase
      end
`ifdef WB_SPI_IRQ_EN
      spi_irq <= irq_en & rxv_n;
`endif
    end
  end

  spi_shift_engine #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_eng (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .tx    (wb_dat_i[DATA_W-1:0]),
    .len   (eff_len),
    .cpol  (cpol),
    .cpha  (cpha),
    .lsb   (lsb),
    .div   (div_r),
    .miso  (spi_miso),
    .busy  (busy),
    .done  (done),
    .rx    (rx),
    .sck   (spi_sck),
    .mosi  (spi_mosi)
  );

endmodule

// File: tb/tb_wb_spi_master.sv
// Self-checking bench for wb_spi_master: register table, loopback frames,
// write collision and mid-frame reset.
module tb_wb_spi_master;
  import wb_spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic        spi_sck, spi_mosi, spi_miso, miso_drv, loop;
  logic [3:0]  spi_cs_n;
`ifdef WB_SPI_IRQ_EN
  logic        spi_irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        bit_q[$];

  always #5 clk = ~clk;
  assign spi_miso = loop ? spi_mosi : miso_drv;

  wb_spi_master #(.DATA_W(32), .NCS(4), .DIV_W(16)) dut (
`ifdef WB_SPI_IRQ_EN
    .spi_irq  (spi_irq),
`endif
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_ack_o (wb_ack_o),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read expectations go through exp_q and are retired when the ack arrives.
  task automatic bus(input bit w, input logic [2:0] off, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    int n;
    logic [31:0] e;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
    wb_adr_i = {27'd0, off, 2'b00}; wb_dat_i = d;
    if (!w) exp_q.push_back(exp);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 16);
    if (!wb_ack_o) begin
      n_cmp++; n_err++;
      $display("FAIL %s_ack: got ack 0 expected 1", name);
      if (!w) e = exp_q.pop_front();
    end else if (!w) begin
      e = exp_q.pop_front();
      chk(name, wb_dat_o, e);
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  off;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first, last, ntr, sp_err, rises;
    bit found;
    logic prev;
    logic [15:0] t16;

    tbl[0]  = '{0, REG_STATUS, 32'h0, 32'h0,     "rst_status"};
    tbl[1]  = '{0, REG_CTRL,   32'h0, 32'h0700,  "rst_ctrl"};
    tbl[2]  = '{0, REG_DIV,    32'h0, 32'hFFFF,  "rst_div"};
    tbl[3]  = '{0, REG_DATA,   32'h0, 32'h0,     "rst_data"};
    tbl[4]  = '{0, REG_CS,     32'h0, 32'h0,     "rst_cs"};
    tbl[5]  = '{1, REG_CS,     32'h1, 32'h0,     "wr_cs"};
    tbl[6]  = '{1, REG_DIV,    32'h1, 32'h0,     "wr_div"};
    tbl[7]  = '{1, REG_CTRL,   32'h0001_1F07, 32'h0, "wr_ctrl"};
`ifdef WB_SPI_IRQ_EN
    tbl[8]  = '{0, REG_CTRL,   32'h0, 32'h0001_1F07, "rd_ctrl"};
`else
    tbl[8]  = '{0, REG_CTRL,   32'h0, 32'h0000_1F07, "rd_ctrl"};
`endif
    tbl[9]  = '{1, REG_CTRL,   32'h0700, 32'h0,  "wr_ctrl_mode0"};
    tbl[10] = '{1, 3'd5,       32'hDEAD, 32'h0,  "wr_unmapped"};
    tbl[11] = '{0, 3'd5,       32'h0, 32'h0,     "rd_unmapped"};
    tbl[12] = '{0, REG_DIV,    32'h0, 32'h1,     "rd_div"};
    tbl[13] = '{0, REG_CS,     32'h0, 32'h1,     "rd_cs"};

    reset = 1'b1; loop = 1'b1; miso_drv = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sck",   {31'd0, spi_sck},  32'h0);
    chk("rst_mosi",  {31'd0, spi_mosi}, 32'h0);
    chk("rst_cs_n",  {28'd0, spi_cs_n}, 32'hF);
    chk("rst_ack",   {31'd0, wb_ack_o}, 32'h0);
    chk("rst_dat_o", wb_dat_o,          32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      bus(tbl[i].w, tbl[i].off, tbl[i].d, tbl[i].exp, tbl[i].name);

    // Mode 0, DIV=1, 8-bit loopback: edges every 2 clk, first at +2, last at +32.
    bus(1, REG_DATA, 32'hA5, 32'h0, "wr_a5");
    chk("a5_cs_n", {28'd0, spi_cs_n}, 32'hE);
    first = -1; last = -1; ntr = 0; sp_err = 0; prev = spi_sck;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (spi_sck !== prev) begin
        ntr++;
        if (first < 0) first = k;
        else if (k - last != 2) sp_err++;
        last = k; prev = spi_sck;
      end
    end
    chk("a5_first_edge", first, 2);
    chk("a5_last_edge",  last, 32);
    chk("a5_edges",      ntr, 16);
    chk("a5_spacing",    sp_err, 0);
    bus(0, REG_STATUS, 0, 32'h2,  "a5_status_rxv");
    bus(0, REG_DATA,   0, 32'hA5, "a5_data");
    bus(0, REG_STATUS, 0, 32'h0,  "a5_status_clr");

    // Mode 3, LSB-first, 16 bits; MOSI sampled at each trailing (rising) edge.
    bus(1, REG_CTRL, 32'h0F07, 32'h0, "wr_ctrl_m3");
    repeat (2) @(posedge clk); #1;
    chk("m3_idle_sck", {31'd0, spi_sck}, 32'h1);
    t16 = 16'h1234;
    for (int i = 0; i < 16; i++) bit_q.push_back(t16[i]);
    bus(1, REG_DATA, 32'h1234, 32'h0, "wr_1234");
    prev = spi_sck;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (prev === 1'b0 && spi_sck === 1'b1 && bit_q.size() > 0)
        chk($sformatf("m3_bit%0d", 16 - bit_q.size()), {31'd0, spi_mosi}, {31'd0, bit_q.pop_front()});
      prev = spi_sck;
    end
    chk("m3_bits_left", bit_q.size(), 0);
    chk("m3_end_sck", {31'd0, spi_sck}, 32'h1);
    bus(0, REG_DATA, 0, 32'h1234, "m3_data");
    bus(1, REG_CTRL, 32'h0700, 32'h0, "wr_ctrl_m0");

    // Second DATA write while busy is dropped and flags wcol.
    bus(1, REG_DATA, 32'h3C, 32'h0, "wr_3c");
    bus(1, REG_DATA, 32'hC3, 32'h0, "wr_c3");
    bus(0, REG_STATUS, 0, 32'h5, "wcol_status");
    bus(0, REG_STATUS, 0, 32'h1, "wcol_cleared");
    repeat (40) @(posedge clk);
    bus(0, REG_STATUS, 0, 32'h2,  "wcol_done");
    bus(0, REG_DATA,   0, 32'h3C, "wcol_data");

    // Reset during bit 3 aborts the frame.
    bus(1, REG_DATA, 32'h5A, 32'h0, "wr_5a");
    rises = 0; found = 0; prev = spi_sck;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (prev === 1'b0 && spi_sck === 1'b1) rises++;
      if (rises == 4) found = 1;
      prev = spi_sck;
    end
    chk("abort_reached_bit3", {31'd0, found}, 32'h1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_sck",  {31'd0, spi_sck},  32'h0);
    chk("abort_mosi", {31'd0, spi_mosi}, 32'h0);
    chk("abort_cs_n", {28'd0, spi_cs_n}, 32'hF);
    @(negedge clk); reset = 1'b0;
    bus(0, REG_STATUS, 0, 32'h0, "abort_status");
    bus(0, REG_DATA,   0, 32'h0, "abort_data");
    bus(0, REG_CTRL,   0, 32'h0700, "abort_ctrl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
